// File: rtl/aes_decryption.sv
// rtl/aes_decryption.sv - iterative AES-128 inverse cipher, one round per clock.
// Define AES_DEC_BUSY_EN to add the registered busy output.
module aes_decryption (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] cipher,
    output logic         done
`ifdef AES_DEC_BUSY_EN
    ,
    output logic         busy
`endif
);

    // Byte x lives at bits [8*(255-x) +: 8]; first listed byte is entry 0.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    typedef enum logic [1:0] {IDLE, EXPAND, INIT, ROUND} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] state;
    logic [127:0] rk [0:10];

    function automatic logic [7:0] sub_fwd(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sub_inv(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sub_fwd(prev[23:16]), sub_fwd(prev[15:8]), sub_fwd(prev[7:0]), sub_fwd(prev[31:24])}
             ^ {rc, 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] me [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] m9 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*(3-i) +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            me[i] = x8[i] ^ x4[i] ^ x2[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r rotates right by r, so output column c takes row r from column (c-r) mod 4.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[8*(15-4*c-r) +: 8] = sub_inv(s[8*(15-4*((c-r)&3)-r) +: 8]);
        t = t ^ k;
        if (!last)
            for (int c = 0; c < 4; c++)
                t[32*(3-c) +: 32] = inv_mix_col(t[32*(3-c) +: 32]);
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm    <= IDLE;
            done   <= 1'b0;
            cipher <= '0;
            cnt    <= '0;
`ifdef AES_DEC_BUSY_EN
            busy   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
`ifdef AES_DEC_BUSY_EN
                    busy <= start;
`endif
                    if (start) begin
                        state <= data;
                        rk[0] <= key;
                        cnt   <= 4'd1;
                        fsm   <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= key_step(rk[cnt - 4'd1], rcon(cnt));
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd10)
                        fsm <= INIT;
                end
                INIT: begin
                    state <= state ^ rk[10];
                    cnt   <= 4'd9;
                    fsm   <= ROUND;
                end
                ROUND: begin
                    if (cnt == 4'd0) begin
                        cipher <= inv_round(state, rk[0], 1'b1);
                        done   <= 1'b1;
                        fsm    <= IDLE;
                    end else begin
                        state <= inv_round(state, rk[cnt], 1'b0);
                        cnt   <= cnt - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decryption.sv
// tb/tb_aes_decryption.sv - self-checking bench for aes_decryption against a GF(2^8)-derived AES model.
module tb_aes_decryption;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] data = '0;
    logic [127:0] key = '0;
    logic [127:0] cipher;
    logic         done;
`ifdef AES_DEC_BUSY_EN
    logic         busy;
`endif

    aes_decryption dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (data),
        .key    (key),
        .cipher (cipher),
        .done   (done)
`ifdef AES_DEC_BUSY_EN
        ,
        .busy   (busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fsb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic void build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fsb[x] = s;
            isb[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   rc, acc;
        logic [31:0]  tw;
        logic [127:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {fsb[tw[23:16]], fsb[tw[15:8]], fsb[tw[7:0]], fsb[tw[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = isb[s[4*((c-q+4)%4)+q]] ^ w[4*rnd+c][31-8*q -: 8];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) begin
                    if (rnd != 0) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-q+4)%4], t[4*c+j]);
                        s[4*c+q] = acc;
                    end else begin
                        s[4*c+q] = t[4*c+q];
                    end
                end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Timing model: accepted at E0 when idle, result and done appear after E21, idle again from E22.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           chk_en = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_cipher = '0;
    logic [127:0] m_res = '0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_busy   <= 1'b0;
            m_cipher <= '0;
            chk_en   <= 1'b1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_res  <= aes_ref(key, data);
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 20) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_cipher <= m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (done !== m_done) begin
                errors++;
                $display("FAIL done_cycle @%0t: got %b expected %b", $time, done, m_done);
            end
            checks++;
            if (cipher !== m_cipher) begin
                errors++;
                $display("FAIL cipher_cycle @%0t: got %h expected %h", $time, cipher, m_cipher);
            end
`ifdef AES_DEC_BUSY_EN
            checks++;
            if (busy !== (m_busy | m_done)) begin
                errors++;
                $display("FAIL busy_cycle @%0t: got %b expected %b", $time, busy, m_busy | m_done);
            end
`endif
        end
    end

    // Called at a negedge with the FSM idle; returns at the negedge where done is seen.
    task automatic op(input string name, input logic [127:0] k, input logic [127:0] d,
                      input logic [127:0] exp, input int repulse, input int rst_at);
        int lat;
        lat = 0;
        key = k; data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data = {$urandom, $urandom, $urandom, $urandom};
        key  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i <= 40; i++) begin
            start = (i == repulse);
            rst   = (i == rst_at);
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b0;
                start = 1'b0;
                check128({name, "_rst_done"}, {127'd0, done}, 128'd0);
                check128({name, "_rst_cipher"}, cipher, 128'd0);
                return;
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected 21 (0 means timeout)", name, lat);
        end
        check128({name, "_result"}, cipher, exp);
    endtask

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] D_SP = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P_SP = 128'h6bc1bee22e409f96e93d7e117393172a;

    initial begin
        logic [127:0] k, d;
        build_tables();
        check128("model_sbox_00", {120'd0, fsb[0]}, 128'h63);
        check128("model_sbox_53", {120'd0, fsb[8'h53]}, 128'hed);
        check128("model_c1", aes_ref(K_C1, D_C1), P_C1);
        check128("model_b", aes_ref(K_B, D_B), P_B);
        check128("model_sp800", aes_ref(K_B, D_SP), P_SP);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check128("reset_done", {127'd0, done}, 128'd0);
        check128("reset_cipher", cipher, 128'd0);

        op("c1", K_C1, D_C1, P_C1, 0, 0);
        op("fips_b", K_B, D_B, P_B, 0, 0);
        op("sp800", K_B, D_SP, P_SP, 0, 0);
        op("busy_ignore", K_B, D_B, P_B, 5, 0);
        op("mid_reset", K_C1, D_C1, P_C1, 0, 8);
        repeat (30) @(negedge clk);
        op("c1_after_rst", K_C1, D_C1, P_C1, 0, 0);

        rst = 1'b1; start = 1'b1; key = K_C1; data = D_C1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check128("rst_start_cipher", cipher, 128'd0);
        repeat (30) @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            k = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            op("random", k, d, aes_ref(k, d), $urandom_range(0, 21), 0);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decryption.md
# aes_decryption

Iterative AES-128 decryption core (FIPS-197 inverse cipher). It accepts a 128-bit ciphertext and a 128-bit cipher key on a one-cycle start strobe. It expands the key schedule internally, runs ten inverse rounds at one round per clock, and then presents the 128-bit plaintext with a one-cycle done pulse. The block is a standalone datapath leaf; it pairs with the AES encryption core and sits behind any bus or stream wrapper.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- data  in  128  ciphertext. Bits [127:120] are FIPS byte 0; the state is column-major.
- key  in  128  AES-128 cipher key, same byte order as data.
- cipher  out  128  decrypted plaintext, registered.
- done  out  1  one-cycle pulse when cipher is updated.

## Operation
- Registers:
  - state (128 bits).
  - rk[0..10] round keys (11×128 bits).
  - cnt (4 bits).
  - FSM: IDLE, EXPAND, INIT, ROUND.
- IDLE:
  - On start=1, latch state<=data, rk[0]<=key, cnt<=1, and go to EXPAND.
  - data and key may change after the start edge.
- EXPAND:
  - Compute rk[cnt] from rk[cnt-1] with the standard schedule: RotWord, SubWord (forward S-box), Rcon[cnt] = 01,02,04,08,10,20,40,80,1b,36.
  - Then cnt<=cnt+1.
  - After rk[10] is written, go to INIT.
- INIT: state<=state^rk[10]; cnt<=9; go to ROUND.
- ROUND: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk[cnt]) when cnt≠0. Then cnt<=cnt-1.
- ROUND, cnt=0:
  - Compute the final round, which omits InvMixColumns.
  - cipher<=result, done<=1, go to IDLE.
- Arithmetic:
  - InvMixColumns uses GF(2^8) with polynomial 0x11b and matrix {0e,0b,0d,09}.
  - InvSubBytes uses the 256-entry inverse S-box as a combinational table.
- start while not in IDLE is ignored; it is not queued.
- cipher holds its last value until the next completion.
- rst at any cycle, including mid-operation:
  - FSM<=IDLE, done<=0, cipher<=0, cnt<=0.
  - The operation in flight is abandoned.
  - The state and rk contents are don't-care.
- Simultaneous rst and start: rst wins and start is dropped.

## Timing
- Start accepted at edge E0.
- EXPAND occupies E1–E10. INIT is at E11. ROUND occupies E12–E21.
- done=1 and cipher is valid for the cycle following E21, i.e. a latency of 21 clocks from the start edge.
- done is high for exactly one cycle.
- A new start is accepted on the edge right after done goes high (FSM is in IDLE). Throughput is one block per 22 cycles.
- Reset values: done=0, cipher=128'h0.

## Configuration
- AES_DEC_BUSY_EN:
  - When defined, the block adds output port busy (1 bit). busy is registered and is 1 from the edge after start is accepted through the cycle done is asserted; otherwise it is 0. busy resets to 0.
  - When undefined, the port is absent and behaviour is otherwise identical.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a, one-cycle start -> done after 21 clocks, cipher=00112233445566778899aabbccddeeff.
- FIPS-197 B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> cipher=3243f6a8885a308d313198a2e0370734.
  - Immediately follow with SP800-38A data 3ad77bb40d7a3660a89ecaf32466ef97 under the same key -> 6bc1bee22e409f96e93d7e117393172a.
- Busy-ignore: pulse start again at E5 with different data -> the first result is unaffected and exactly one done occurs.
- Input volatility: change data and key at E1 -> the result matches the values latched at E0.
- Reset mid-operation: assert rst at E8 -> next cycle done=0 and cipher=0, no done pulse appears. A subsequent C.1 request completes correctly.
- AES_DEC_BUSY_EN build: busy rises after E0, falls after the done cycle, and is 0 after reset.
